// File: rtl/neopixel_strand_ctrl_gen.sv
// neopixel_strand_ctrl_gen
// Single-wire WS2812-class strand driver with a double-buffered frame store.
// Hosts write colour bytes into a shadow buffer. send_it copies the shadow
// into an active buffer, which is then serialised on neo_data. Because only
// the active buffer is read during a frame, the next frame can be loaded
// while the current one is still being sent.
//
// Ports
//   clock          system clock, single domain
//   reset          synchronous, active-high
//   color_level    byte to write
//   color_index    0=red 1=green 2=blue 3=white
//   pixel_index    target pixel
//   load_color     write color_level into shadow[pixel_index][color_index]
//   clear_all      zero the whole shadow buffer (wins over load_color)
//   send_it        start a frame (accepted in IDLE only)
//   neo_data       registered serial output
//   ready_to_load  shadow accepts writes
//   ready_to_send  send_it is accepted this cycle
//   busy           frame or latch interval in progress
//
// state  | meaning
// IDLE   | line low, waiting for send_it
// HIGH   | high phase of the current bit (T1H or T0H cycles)
// LOW    | low phase of the current bit (T1L or T0L cycles)
// LATCH  | line held low for LATCH_CYCLES before the next frame
module neopixel_strand_ctrl_gen #(
   parameter int NUM_PIXELS   = 5,
   parameter int CHANNELS     = 3,
   parameter int T1H          = 35,
   parameter int T1L          = 30,
   parameter int T0H          = 18,
   parameter int T0L          = 40,
   parameter int LATCH_CYCLES = 2500,
   localparam int IDX_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       color_level,
   input  logic [1:0]       color_index,
   input  logic [IDX_W-1:0] pixel_index,
   input  logic             load_color,
   input  logic             clear_all,
   input  logic             send_it,
   output logic             neo_data,
   output logic             ready_to_load,
   output logic             ready_to_send,
   output logic             busy
);

   localparam int NB     = NUM_PIXELS * CHANNELS;
   localparam int NBITS  = NB * 8;
   localparam int BIT_W  = $clog2(NBITS + 1);
   localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int MAX_H  = (T1H > T0H) ? T1H : T0H;
   localparam int MAX_L  = (T1L > T0L) ? T1L : T0L;
   localparam int MAX_HL = (MAX_H > MAX_L) ? MAX_H : MAX_L;
   localparam int MAX_T  = (MAX_HL > LATCH_CYCLES) ? MAX_HL : LATCH_CYCLES;
   localparam int CNT_W  = $clog2(MAX_T + 1);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_LATCH} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               neo_data_q, neo_data_d;
   logic [7:0]         shadow_q [NB];
   logic [7:0]         shadow_d [NB];
   logic [7:0]         active_q [NB];
   logic [7:0]         active_d [NB];
   logic [7:0]         cur_byte;
   logic               cur_bit;
   logic [CNT_W-1:0]   t_high_m1, t_low_m1;

   // Buffers are stored in wire order, so byte slot c of a pixel holds
   // G, R, B, W for c = 0..3. This maps a slot back to its color_index.
   function automatic logic [1:0] slot_color(input int c);
      case (c)
         0:       return 2'd1;
         1:       return 2'd0;
         2:       return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   // Out-of-range pixels and the white slot on RGB builds never match,
   // so those writes fall through untouched.
   always_comb begin
      shadow_d = shadow_q;
      if (clear_all) begin
         for (int i = 0; i < NB; i++) shadow_d[i] = '0;
      end else if (load_color) begin
         for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
               if (pixel_index == IDX_W'(p) && color_index == slot_color(c))
                  shadow_d[p*CHANNELS + c] = color_level;
            end
         end
      end
   end

   assign cur_byte  = active_q[bit_cnt_q[3 +: BYTE_W]];
   assign cur_bit   = cur_byte[3'd7 - bit_cnt_q[2:0]];
   assign t_high_m1 = cur_bit ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
   assign t_low_m1  = cur_bit ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      active_d  = active_q;
      case (state_q)
         S_IDLE: begin
            if (send_it) begin
               // snapshot includes any write made in this same cycle
               active_d  = shadow_d;
               bit_cnt_d = '0;
               cnt_d     = '0;
               state_d   = S_HIGH;
            end
         end
         S_HIGH: begin
            if (cnt_q == t_high_m1) begin
               cnt_d   = '0;
               state_d = S_LOW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LOW: begin
            if (cnt_q == t_low_m1) begin
               cnt_d = '0;
               if (bit_cnt_q == BIT_W'(NBITS - 1)) begin
                  state_d = S_LATCH;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  state_d   = S_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The pin register trails the state by one cycle, so each phase on the
   // wire lasts exactly as many cycles as the state does.
   assign neo_data_d = (state_q == S_HIGH);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         neo_data_q <= 1'b0;
         for (int i = 0; i < NB; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         neo_data_q <= neo_data_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
      end
   end

   assign neo_data      = neo_data_q;
   assign ready_to_load = !reset;
   assign ready_to_send = !reset && (state_q == S_IDLE);
   assign busy          = !reset && (state_q != S_IDLE);

endmodule
